// File: rtl/mem_access_stage.sv
// Memory-access stage: issues loads/stores on a req/ack port and fills the MEM/WB slot.
// Latency: non-memory ops 1 cycle; memory ops complete on the dmem_ack edge (minimum 1 cycle).
// Backpressure: stall is held while a request is outstanding and drops in the ack cycle.
module mem_access_stage #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic              reg_write,
  input  logic [4:0]        rd_addr,
  input  logic              mem_to_reg,
  input  logic              flush,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [XLEN-1:0]   mem_result,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd_addr,
  output logic              wb_mem_to_reg,
  output logic              wb_valid,
  output logic              misalign_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_nxt;

  // Request and instruction fields captured while waiting for the ack
  logic [ADDR_W-1:0] q_addr;
  logic [XLEN-1:0]   q_wdata;
  logic [XLEN-1:0]   q_alu;
  logic [7:0]        q_wstrb;
  logic              q_we;
  logic [2:0]        q_off;
  logic [2:0]        q_funct3;
  logic              q_reg_write;
  logic [4:0]        q_rd;
  logic              q_mem_to_reg;
  logic              q_kill;

  // Decode of the instruction presented in IDLE
  logic [2:0]        in_off;
  logic              in_access;
  logic              in_live;
  logic              in_aligned;
  logic              in_issue;
  logic              in_misalign;
  logic              in_alu;
  logic [XLEN-1:0]   in_wdata;
  logic [7:0]        in_wstrb;
  logic [ADDR_W-1:0] in_addr;

  // Fields of whichever access is currently on the bus
  logic              in_acc;
  logic [2:0]        act_off;
  logic [2:0]        act_funct3;
  logic              act_load;
  logic [XLEN-1:0]   act_alu;
  logic              act_reg_write;
  logic [4:0]        act_rd;
  logic              act_mem_to_reg;
  logic              act_drop;
  logic              ack_hit;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_val;

  assign in_off    = alu_result[2:0];
  assign in_access = mem_read | mem_write;
  // Reset gates the request path so the bus is quiet while rst_n is low.
  assign in_live   = rst_n && (state == IDLE) && ex_valid && !flush;
  assign in_issue    = in_live && in_access && in_aligned;
  assign in_misalign = in_live && in_access && !in_aligned;
  assign in_alu      = in_live && !in_access;
  assign in_addr     = ADDR_W'({alu_result[XLEN-1:3], 3'b000});

  // Natural alignment check from the access size in funct3[1:0]
  always_comb begin
    in_aligned = 1'b1;
    case (funct3[1:0])
      2'b00:   in_aligned = 1'b1;
      2'b01:   in_aligned = ~in_off[0];
      2'b10:   in_aligned = (in_off[1:0] == 2'b00);
      default: in_aligned = (in_off == 3'b000);
    endcase
  end

  // Store lane replication and byte enables; loads keep wstrb at zero
  always_comb begin
    in_wdata = store_data;
    in_wstrb = 8'h00;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          in_wdata = {8{store_data[7:0]}};
          in_wstrb = 8'h01 << in_off;
        end
        2'b01: begin
          in_wdata = {4{store_data[15:0]}};
          in_wstrb = 8'h03 << in_off;
        end
        2'b10: begin
          in_wdata = {2{store_data[31:0]}};
          in_wstrb = 8'h0F << in_off;
        end
        default: begin
          in_wdata = store_data;
          in_wstrb = 8'hFF;
        end
      endcase
    end
  end

  assign in_acc = (state == ACCESS);

  // Bus outputs come straight from the inputs on the first cycle, then from the captured copy
  always_comb begin
    dmem_req   = in_issue | in_acc;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_wstrb = 8'h00;
    if (in_acc) begin
      dmem_we    = q_we;
      dmem_addr  = q_addr;
      dmem_wdata = q_wdata;
      dmem_wstrb = q_wstrb;
    end else if (in_issue) begin
      dmem_we    = mem_write;
      dmem_addr  = in_addr;
      dmem_wdata = in_wdata;
      dmem_wstrb = in_wstrb;
    end
  end

  assign ack_hit = dmem_ack && dmem_req;
  assign stall   = dmem_req && !dmem_ack;

  assign act_off        = in_acc ? q_off        : in_off;
  assign act_funct3     = in_acc ? q_funct3     : funct3;
  assign act_load       = in_acc ? !q_we        : !mem_write;
  assign act_alu        = in_acc ? q_alu        : alu_result;
  assign act_reg_write  = in_acc ? q_reg_write  : reg_write;
  assign act_rd         = in_acc ? q_rd         : rd_addr;
  assign act_mem_to_reg = in_acc ? q_mem_to_reg : mem_to_reg;
  // A flush seen during the access, now or earlier, discards the result.
  assign act_drop       = in_acc && (q_kill || flush);

  assign shifted = dmem_rdata >> {act_off, 3'b000};

  // Load extraction: size and signedness from funct3; 111 behaves as LD
  always_comb begin
    load_val = shifted;
    case (act_funct3)
      3'b000:  load_val = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_val = {56'd0, shifted[7:0]};
      3'b101:  load_val = {48'd0, shifted[15:0]};
      3'b110:  load_val = {32'd0, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: wait in ACCESS until the memory acknowledges
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_issue && !dmem_ack) state_nxt = ACCESS;
      ACCESS:  if (dmem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the outstanding access and track a flush that arrives mid-access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_addr       <= '0;
      q_wdata      <= '0;
      q_alu        <= '0;
      q_wstrb      <= 8'h00;
      q_we         <= 1'b0;
      q_off        <= 3'b000;
      q_funct3     <= 3'b000;
      q_reg_write  <= 1'b0;
      q_rd         <= 5'd0;
      q_mem_to_reg <= 1'b0;
      q_kill       <= 1'b0;
    end else if (in_issue && !dmem_ack) begin
      q_addr       <= in_addr;
      q_wdata      <= in_wdata;
      q_alu        <= alu_result;
      q_wstrb      <= in_wstrb;
      q_we         <= mem_write;
      q_off        <= in_off;
      q_funct3     <= funct3;
      q_reg_write  <= reg_write;
      q_rd         <= rd_addr;
      q_mem_to_reg <= mem_to_reg;
      q_kill       <= 1'b0;
    end else if (in_acc) begin
      q_kill <= dmem_ack ? 1'b0 : (q_kill | flush);
    end
  end

  // MEM/WB boundary register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_result    <= '0;
      wb_reg_write  <= 1'b0;
      wb_rd_addr    <= 5'd0;
      wb_mem_to_reg <= 1'b0;
      wb_valid      <= 1'b0;
      misalign_err  <= 1'b0;
    end else if (ack_hit && !act_drop) begin
      mem_result    <= act_load ? load_val : act_alu;
      wb_reg_write  <= act_reg_write;
      wb_rd_addr    <= act_rd;
      wb_mem_to_reg <= act_mem_to_reg;
      wb_valid      <= 1'b1;
      misalign_err  <= 1'b0;
    end else if (in_alu) begin
      mem_result    <= alu_result;
      wb_reg_write  <= reg_write;
      wb_rd_addr    <= rd_addr;
      wb_mem_to_reg <= mem_to_reg;
      wb_valid      <= 1'b1;
      misalign_err  <= 1'b0;
    end else if (in_misalign) begin
      wb_reg_write  <= 1'b0;
      wb_valid      <= 1'b1;
      misalign_err  <= 1'b1;
    end else begin
      wb_reg_write  <= 1'b0;
      wb_valid      <= 1'b0;
      misalign_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed cases plus randomized instructions.
// Latency: one instruction at a time, each followed by an idle cycle.
// Backpressure: ack delay and flush timing are chosen per instruction.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic        mem_to_reg;
  logic        flush;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic [63:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic        wb_mem_to_reg;
  logic        wb_valid;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  // Last committed writeback values, used to confirm fields hold while idle
  logic [63:0] exp_result;
  logic [4:0]  exp_rd;
  logic        exp_m2r;
  bit          res_known;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_result(alu_result),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .reg_write(reg_write), .rd_addr(rd_addr),
    .mem_to_reg(mem_to_reg), .flush(flush), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_valid(wb_valid),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: bytes above the access start, truncated to size, extended by signedness
  function automatic logic [63:0] ref_load(logic [2:0] f3, logic [63:0] a, logic [63:0] rdat);
    int          n;
    logic [63:0] v, mask;
    n = 1 << f3[1:0];
    v = rdat >> (8 * a[2:0]);
    if (n == 8) return v;
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [63:0] ref_wdata(logic [2:0] f3, logic [63:0] sd);
    int          n;
    logic [63:0] w, mask;
    n = 1 << f3[1:0];
    if (n == 8) return sd;
    mask = (64'd1 << (8 * n)) - 64'd1;
    w = '0;
    for (int i = 0; i < 8 / n; i++) w = w | ((sd & mask) << (8 * n * i));
    return w;
  endfunction

  function automatic logic [7:0] ref_wstrb(logic [2:0] f3, logic [63:0] a);
    int n;
    n = 1 << f3[1:0];
    return 8'(((1 << n) - 1) << a[2:0]);
  endfunction

  task automatic drive_idle();
    ex_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    flush     = 1'b0;
    dmem_ack  = 1'b0;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 read+write (behaves as store).
  // flush_at: -1 none, 0 on the issue cycle, k>0 on the k-th wait cycle.
  // Entered and left just after a rising edge.
  task automatic run_instr(input int kind, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] sdata, input logic [63:0] rdat, input int delay,
                           input int flush_at, input logic rw, input logic [4:0] rd,
                           input logic m2r);
    bit          access, aligned, killed, issue, misal, is_store, dropped;
    int          n;
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_wstrb;
    access   = (kind != 0);
    is_store = (kind >= 2);
    n        = 1 << f3[1:0];
    aligned  = (addr[2:0] % n) == 0;
    killed   = (flush_at == 0);
    issue    = access && aligned && !killed;
    misal    = access && !aligned && !killed;
    dropped  = issue && flush_at >= 1;
    e_addr   = {addr[63:3], 3'b000};
    e_wdata  = ref_wdata(f3, sdata);
    e_wstrb  = is_store ? ref_wstrb(f3, addr) : 8'h00;

    ex_valid   = 1'b1;
    alu_result = addr;
    store_data = sdata;
    mem_read   = (kind == 1 || kind == 3);
    mem_write  = (kind == 2 || kind == 3);
    funct3     = f3;
    reg_write  = rw;
    rd_addr    = rd;
    mem_to_reg = m2r;
    flush      = killed;
    dmem_rdata = rdat;
    dmem_ack   = issue && delay == 0;
    @(negedge clk);
    check("req_issue", dmem_req, issue);
    check("stall_issue", stall, issue && delay > 0);
    if (issue) begin
      check("we_issue", dmem_we, is_store);
      check("addr_issue", dmem_addr, e_addr);
      check("wstrb_issue", dmem_wstrb, e_wstrb);
      if (is_store) check("wdata_issue", dmem_wdata, e_wdata);
    end

    if (issue) begin
      for (int k = 1; k <= delay; k++) begin
        @(posedge clk); #1;
        flush    = (k == flush_at);
        dmem_ack = (k == delay);
        @(negedge clk);
        check("req_hold", dmem_req, 1);
        check("stall_hold", stall, k != delay);
        check("we_hold", dmem_we, is_store);
        check("addr_hold", dmem_addr, e_addr);
        check("wstrb_hold", dmem_wstrb, e_wstrb);
        if (is_store) check("wdata_hold", dmem_wdata, e_wdata);
        check("wbv_wait", wb_valid, 0);
        check("wbrw_wait", wb_reg_write, 0);
      end
    end

    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    if (killed || dropped) begin
      check("wbv_kill", wb_valid, 0);
      check("wbrw_kill", wb_reg_write, 0);
      check("err_kill", misalign_err, 0);
      if (dropped) res_known = 0;
    end else if (misal) begin
      check("wbv_mis", wb_valid, 1);
      check("wbrw_mis", wb_reg_write, 0);
      check("err_mis", misalign_err, 1);
      res_known = 0;
    end else begin
      exp_result = (kind == 1) ? ref_load(f3, addr, rdat) : addr;
      exp_rd     = rd;
      exp_m2r    = m2r;
      res_known  = 1;
      check("wbv", wb_valid, 1);
      check("wbrw", wb_reg_write, rw);
      check("err", misalign_err, 0);
      check("result", mem_result, exp_result);
      check("rd", wb_rd_addr, exp_rd);
      check("m2r", wb_mem_to_reg, exp_m2r);
    end

    @(posedge clk); #1;
    @(negedge clk);
    check("wbv_idle", wb_valid, 0);
    check("wbrw_idle", wb_reg_write, 0);
    check("err_idle", misalign_err, 0);
    check("req_idle", dmem_req, 0);
    check("stall_idle", stall, 0);
    if (res_known) begin
      check("result_hold", mem_result, exp_result);
      check("rd_hold", wb_rd_addr, exp_rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_req"}, dmem_req, 0);
    check({tag, "_we"}, dmem_we, 0);
    check({tag, "_addr"}, dmem_addr, 0);
    check({tag, "_wdata"}, dmem_wdata, 0);
    check({tag, "_wstrb"}, dmem_wstrb, 0);
    check({tag, "_result"}, mem_result, 0);
    check({tag, "_wbrw"}, wb_reg_write, 0);
    check({tag, "_rd"}, wb_rd_addr, 0);
    check({tag, "_m2r"}, wb_mem_to_reg, 0);
    check({tag, "_wbv"}, wb_valid, 0);
    check({tag, "_err"}, misalign_err, 0);
  endtask

  initial begin
    int          kind, delay, flush_at, n, roll;
    logic [2:0]  f3;
    logic [63:0] addr;

    rst_n      = 1'b0;
    alu_result = '0;
    store_data = '0;
    funct3     = 3'b000;
    reg_write  = 1'b0;
    rd_addr    = 5'd0;
    mem_to_reg = 1'b0;
    dmem_rdata = '0;
    drive_idle();
    res_known  = 1;
    exp_result = '0;
    exp_rd     = 5'd0;
    exp_m2r    = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_instr(1, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 2, -1, 1, 5'd3, 1);
    run_instr(1, 3'b100, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1, -1, 1, 5'd4, 1);
    run_instr(1, 3'b110, 64'h1004, 64'h0, 64'hDEAD_BEEF_0000_0000, 0, -1, 1, 5'd5, 1);
    run_instr(2, 3'b001, 64'h2006, 64'h1234, 64'h0, 3, -1, 0, 5'd0, 0);
    run_instr(1, 3'b010, 64'h1002, 64'h0, 64'h0, 1, -1, 1, 5'd6, 1);
    run_instr(0, 3'b000, 64'h55, 64'h0, 64'h0, 0, -1, 1, 5'd7, 0);
    run_instr(1, 3'b011, 64'h3000, 64'h0, 64'h1122_3344_5566_7788, 3, 1, 1, 5'd8, 1);
    run_instr(1, 3'b011, 64'h3008, 64'h0, 64'h0123_4567_89AB_CDEF, 2, 2, 1, 5'd9, 1);
    run_instr(1, 3'b111, 64'h3010, 64'h0, 64'hFEDC_BA98_7654_3210, 1, -1, 1, 5'd10, 1);
    run_instr(3, 3'b010, 64'h4004, 64'hCAFE_F00D, 64'h0, 1, -1, 0, 5'd0, 0);
    run_instr(2, 3'b011, 64'h5000, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0, 1, 0, 0, 5'd0, 0);

    // Reset in the middle of an outstanding access
    ex_valid   = 1'b1;
    alu_result = 64'h6000;
    mem_read   = 1'b1;
    funct3     = 3'b011;
    reg_write  = 1'b1;
    rd_addr    = 5'd11;
    @(negedge clk);
    check("rst_pre_req", dmem_req, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    drive_idle();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_req", dmem_req, 0);
    check("post_rst_wbv", wb_valid, 0);
    res_known  = 1;
    exp_result = '0;
    exp_rd     = 5'd0;
    @(posedge clk); #1;

    // Randomized instructions
    for (int it = 0; it < 200; it++) begin
      kind = $urandom_range(0, 3);
      f3   = (kind == 1 || kind == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      n    = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) addr = addr & ~(64'(n) - 64'd1);
      delay    = $urandom_range(0, 3);
      flush_at = -1;
      roll     = $urandom_range(0, 9);
      if (roll == 0) flush_at = 0;
      else if (roll == 1 && delay > 0) flush_at = $urandom_range(1, delay);
      run_instr(kind, f3, addr, {$urandom, $urandom}, {$urandom, $urandom}, delay, flush_at,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage; sits directly upstream of the writeback stage.
- Takes the executed instruction (ALU result, store data, control bits) and performs loads/stores over a req/ack data-memory port.
- Sign/zero-extends load data, then registers the result, destination and control into a MEM/WB boundary that feeds writeback.
- Stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- ADDR_W, 64, data-memory address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  upstream instruction present.
- alu_result  in  XLEN  effective address for loads/stores, otherwise the result.
- store_data  in  XLEN  rs2 value for stores.
- mem_read  in  1  load.
- mem_write  in  1  store.
- funct3  in  3  access size/sign.
- reg_write  in  1  destination write enable.
- rd_addr  in  5  destination register.
- mem_to_reg  in  1  result comes from memory.
- flush  in  1  kill the instruction in this stage.
- stall  out  1  upstream must hold its outputs.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  doubleword-aligned address, {alu_result[63:3],3'b000}.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_wstrb  out  8  byte enables.
- dmem_ack  in  1  access complete; rdata valid in the same cycle.
- dmem_rdata  in  XLEN  doubleword read data.
- mem_result  out  XLEN  to writeback.
- wb_reg_write  out  1  to writeback.
- wb_rd_addr  out  5  to writeback.
- wb_mem_to_reg  out  1  to writeback.
- wb_valid  out  1  MEM/WB slot holds a live instruction.
- misalign_err  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset (rst_n low, async): state = IDLE; all outputs 0, including mem_result, wb_*, dmem_*, stall and misalign_err. Reset mid-access drops the transaction; there is no replay.
- FSM has two states, IDLE and ACCESS.
- IDLE, ex_valid, neither mem_read nor mem_write: next edge registers wb_valid=1, mem_result=alu_result, wb_reg_write=reg_write, wb_rd_addr and wb_mem_to_reg. Latency is 1 cycle.
- IDLE, ex_valid, mem access, aligned:
  - dmem_req, dmem_we, addr, wdata and wstrb drive combinationally in the same cycle.
  - stall=1 combinationally unless dmem_ack=1 in that same cycle.
  - Without ack, go to ACCESS and capture the request fields and the instruction's control bits.
- ACCESS: hold dmem_req=1 and all dmem_* fields stable until dmem_ack; stall=1.
- On dmem_ack (in either state):
  - Register the result: load data for loads, alu_result for stores.
  - Set wb_valid=1 and return to IDLE.
  - stall drops in the ack cycle, so upstream advances on that edge. Minimum load latency is 1 cycle.
- Alignment rule: LH/SH need addr[0]=0; LW/LWU/SW need addr[1:0]=0; LD/SD need addr[2:0]=0.
- Misaligned access:
  - No dmem_req is issued.
  - Next edge: wb_valid=1, wb_reg_write=0, misalign_err=1 for one cycle.
- Load extraction:
  - Shift dmem_rdata right by 8*addr[2:0].
  - funct3 000 LB: sign-extend 8. 001 LH: sign-extend 16. 010 LW: sign-extend 32. 011 LD: full 64.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - 111 is illegal: treated as LD, no error.
- Store lanes:
  - SB: wdata = byte replicated ×8, wstrb = 8'h01 << addr[2:0].
  - SH: wdata = half replicated ×4, wstrb = 8'h03 << addr[2:0].
  - SW: wdata = word replicated ×2, wstrb = 8'h0F << addr[2:0].
  - SD: wdata = store_data, wstrb = 8'hFF.
  - Loads drive wstrb = 0.
- No instruction (ex_valid=0 in IDLE, no ack): next edge writes wb_valid=0 and wb_reg_write=0; the other wb fields hold.
- wb_reg_write is never 1 when wb_valid=0.
- flush in IDLE: the incoming instruction is killed. No dmem_req is issued; next edge wb_valid=0, wb_reg_write=0.
- flush in ACCESS:
  - The bus transaction runs to ack (it cannot be aborted).
  - A sticky kill bit is set; on ack the result is discarded (wb_valid=0, wb_reg_write=0).
  - A store still commits.
- flush and dmem_ack in the same cycle: discard.
- mem_read and mem_write both 1: treated as a store.

Test Plan:
- LB at addr 0x1003, rdata 0x0000_0000_8000_0000, ack after 2 cycles: stall high 2 cycles; mem_result=0xFFFF_FFFF_FFFF_FF80, wb_reg_write=1.
- LBU at the same address with the same data: mem_result=0x80. LWU at 0x1004, rdata 0xDEADBEEF_00000000: mem_result=0x0000_0000_DEAD_BEEF.
- SH at 0x2006, store_data=0x1234: dmem_wstrb=8'hC0, dmem_wdata=0x1234_1234_1234_1234, dmem_we=1. Holding dmem_ack=0 for 3 cycles keeps req and fields stable.
- LW at 0x1002: no dmem_req; misalign_err pulses once; wb_valid=1, wb_reg_write=0.
- ALU instruction, alu_result=0x55, rd=7, reg_write=1: next cycle mem_result=0x55, wb_rd_addr=7, stall never asserted.
- LD issued, flush in ACCESS, ack 2 cycles later: wb_valid=0, wb_reg_write=0. Separately, assert rst_n low mid-ACCESS: all outputs 0 immediately, state IDLE.
